// File: rtl/regfile_access_seq.sv
// regfile_access_seq: command-driven initiator that reads up to two operands from a 16x16 register file, writes the ALU result back and returns it.
module regfile_access_seq #(
    parameter int WIDTH      = 16,
    parameter int RNUM_W     = 5,
    parameter bit PROTECT_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [3:0]        cmd_rs,
    input  logic [3:0]        cmd_rt,
    input  logic [3:0]        cmd_rd,
    input  logic [WIDTH-1:0]  cmd_imm,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_carry,
    output logic [RNUM_W-1:0] rf_rd_regnum,
    input  logic [WIDTH-1:0]  rf_rd_data,
    output logic [RNUM_W-1:0] rf_wr_regnum,
    output logic [WIDTH-1:0]  rf_wr_data,
    output logic              rf_write_enable
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, WB, RESP} state_t;
    localparam logic [2:0] OP_MOV = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
                           OP_OR  = 3'd4, OP_XOR = 3'd5, OP_LDI = 3'd6, OP_RD  = 3'd7;
    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [3:0]       rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [WIDTH-1:0] imm_q, imm_d, a_q, a_d, b_q, b_d, rsp_data_q, rsp_data_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             carry;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
        end
    end
    always_comb begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        res   = op_q == OP_ADD ? sum[WIDTH-1:0] :
                op_q == OP_SUB ? a_q - b_q :
                op_q == OP_AND ? a_q & b_q :
                op_q == OP_OR  ? a_q | b_q :
                op_q == OP_XOR ? a_q ^ b_q :
                op_q == OP_LDI ? imm_q : a_q;
        carry = op_q == OP_ADD ? sum[WIDTH] : op_q == OP_SUB ? a_q < b_q : 1'b0;
    end
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                op_d    = cmd_op;
                rs_d    = cmd_rs;
                rt_d    = cmd_rt;
                rd_d    = cmd_rd;
                imm_d   = cmd_imm;
                state_d = cmd_op == OP_LDI ? WB : RD_A;
            end
            RD_A: begin
                a_d     = rf_rd_data;
                state_d = op_q == OP_MOV ? WB : op_q == OP_RD ? RESP : RD_B;
                // RD bypasses WB, so its response is captured straight off the read port
                if (op_q == OP_RD) begin
                    rsp_data_d  = rf_rd_data;
                    rsp_carry_d = 1'b0;
                end
            end
            RD_B: begin
                b_d     = rf_rd_data;
                state_d = WB;
            end
            WB: begin
                rsp_data_d  = res;
                rsp_carry_d = carry;
                state_d     = RESP;
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    assign cmd_ready       = state_q == IDLE;
    assign rsp_valid       = state_q == RESP;
    assign rsp_data        = rsp_data_q;
    assign rsp_carry       = rsp_carry_q;
    assign rf_rd_regnum    = state_q == RD_A ? RNUM_W'(rs_q) : state_q == RD_B ? RNUM_W'(rt_q) : '0;
    assign rf_wr_regnum    = state_q == WB ? RNUM_W'(rd_q) : '0;
    assign rf_wr_data      = state_q == WB ? res : '0;
    assign rf_write_enable = state_q == WB && !reset && !(PROTECT_R0 && rd_q == 4'd0);
endmodule

// File: tb/tb_regfile_access_seq.sv
// tb_regfile_access_seq: directed vectors against two instances (R0 writable / R0 protected), each backed by its own register-file model.
module tb_regfile_access_seq;
    localparam logic [2:0] MOV = 3'd0, ADD = 3'd1, SUB = 3'd2, AND = 3'd3,
                           OR  = 3'd4, XOR = 3'd5, LDI = 3'd6, RD  = 3'd7;
    typedef struct {
        logic [2:0]  op;
        logic [3:0]  rs, rt, rd;
        logic [15:0] imm, data, pdata;
        logic        carry;
        int          lat, nwr, npwr;
    } vec_t;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    logic        cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic [2:0]  cmd_op = '0;
    logic [3:0]  cmd_rs = '0, cmd_rt = '0, cmd_rd = '0;
    logic [15:0] cmd_imm = '0;
    logic        cmd_ready, rsp_valid, rsp_carry, we;
    logic [15:0] rsp_data, rd_data, wr_data;
    logic [4:0]  rd_regnum, wr_regnum;
    logic        p_cmd_ready, p_rsp_valid, p_rsp_carry, p_we;
    logic [15:0] p_rsp_data, p_rd_data, p_wr_data;
    logic [4:0]  p_rd_regnum, p_wr_regnum;

    regfile_access_seq #(.WIDTH(16), .RNUM_W(5), .PROTECT_R0(1'b0)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_carry(rsp_carry),
        .rf_rd_regnum(rd_regnum), .rf_rd_data(rd_data), .rf_wr_regnum(wr_regnum),
        .rf_wr_data(wr_data), .rf_write_enable(we));
    regfile_access_seq #(.WIDTH(16), .RNUM_W(5), .PROTECT_R0(1'b1)) dut_p (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(p_cmd_ready),
        .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
        .rsp_valid(p_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(p_rsp_data), .rsp_carry(p_rsp_carry),
        .rf_rd_regnum(p_rd_regnum), .rf_rd_data(p_rd_data), .rf_wr_regnum(p_wr_regnum),
        .rf_wr_data(p_wr_data), .rf_write_enable(p_we));

    bit [15:0]   rf [16];
    bit [15:0]   prf [16];
    int          wcnt = 0, pwcnt = 0;
    logic [3:0]  wreg = '0;
    logic [15:0] wdat = '0;
    bit          hi_bits = 1'b0;
    assign rd_data   = rf[rd_regnum[3:0]];
    assign p_rd_data = prf[p_rd_regnum[3:0]];
    always @(posedge clk) begin
        if (we) begin
            rf[wr_regnum[3:0]] <= wr_data;
            wcnt <= wcnt + 1;
            wreg <= wr_regnum[3:0];
            wdat <= wr_data;
        end
        if (p_we) begin
            prf[p_wr_regnum[3:0]] <= p_wr_data;
            pwcnt <= pwcnt + 1;
        end
        if (rd_regnum[4] | wr_regnum[4] | p_rd_regnum[4] | p_wr_regnum[4]) hi_bits <= 1'b1;
    end

    int errors = 0, checks = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [3:0] rs, rt, rd,
                                input logic [15:0] imm, data, pdata, input logic carry,
                                input int lat, nwr, npwr);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.imm = imm; v.data = data;
        v.pdata = pdata; v.carry = carry; v.lat = lat; v.nwr = nwr; v.npwr = npwr;
        return v;
    endfunction

    task automatic run(input vec_t v, input bit ready);
        int w0 = wcnt, p0 = pwcnt, lat = 1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_rs = v.rs; cmd_rt = v.rt; cmd_rd = v.rd;
        cmd_imm = v.imm; rsp_ready = ready;
        chk("cmd_ready_before_accept", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = ~v.op; cmd_rs = ~v.rs; cmd_rt = ~v.rt; cmd_rd = ~v.rd; cmd_imm = ~v.imm;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, v.lat);
        chk("rsp_data", rsp_data, v.data);
        chk("rsp_carry", rsp_carry, v.carry);
        chk("p_rsp_data", {p_rsp_valid, p_rsp_data}, {1'b1, v.pdata});
        if (ready) begin
            @(posedge clk); #1;
            chk("back_to_idle", {cmd_ready, rsp_valid}, 2'b10);
        end
        chk("write_count", wcnt - w0, v.nwr);
        chk("p_write_count", pwcnt - p0, v.npwr);
        if (v.nwr == 1) chk("write_reg_data", {wreg, wdat}, {v.rd, v.data});
    endtask

    vec_t tbl[14];
    initial begin
        bit ok;
        int w0;
        tbl[0]  = mk(LDI, 0, 0, 3,  16'h1234, 16'h1234, 16'h1234, 0, 2, 1, 1);
        tbl[1]  = mk(LDI, 0, 0, 3,  16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 2, 1, 1);
        tbl[2]  = mk(LDI, 0, 0, 4,  16'h0002, 16'h0002, 16'h0002, 0, 2, 1, 1);
        tbl[3]  = mk(ADD, 3, 4, 5,  16'h0000, 16'h0001, 16'h0001, 1, 4, 1, 1);
        tbl[4]  = mk(SUB, 0, 4, 6,  16'h0000, 16'hFFFE, 16'hFFFE, 1, 4, 1, 1);
        tbl[5]  = mk(MOV, 6, 0, 7,  16'h0000, 16'hFFFE, 16'hFFFE, 0, 3, 1, 1);
        tbl[6]  = mk(AND, 3, 6, 8,  16'h0000, 16'hFFFE, 16'hFFFE, 0, 4, 1, 1);
        tbl[7]  = mk(OR,  4, 5, 9,  16'h0000, 16'h0003, 16'h0003, 0, 4, 1, 1);
        tbl[8]  = mk(XOR, 3, 4, 10, 16'h0000, 16'hFFFD, 16'hFFFD, 0, 4, 1, 1);
        tbl[9]  = mk(SUB, 4, 5, 11, 16'h0000, 16'h0001, 16'h0001, 0, 4, 1, 1);
        tbl[10] = mk(LDI, 0, 0, 0,  16'hBEEF, 16'hBEEF, 16'hBEEF, 0, 2, 1, 0);
        tbl[11] = mk(RD,  0, 0, 0,  16'h0000, 16'hBEEF, 16'h0000, 0, 2, 0, 0);
        tbl[12] = mk(LDI, 0, 0, 2,  16'h4001, 16'h4001, 16'h4001, 0, 2, 1, 1);
        tbl[13] = mk(ADD, 2, 2, 2,  16'h0000, 16'h8002, 16'h8002, 0, 4, 1, 1);

        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        chk("reset_handshake", {cmd_ready, rsp_valid, we, p_cmd_ready, p_rsp_valid, p_we}, 6'b100100);
        chk("reset_ports", {rd_regnum, wr_regnum, wr_data, rsp_data, rsp_carry}, '0);

        for (int i = 0; i < 14; i++) run(tbl[i], 1'b1);

        // response held under backpressure
        w0 = wcnt;
        run(mk(RD, 5, 0, 0, 16'h0000, 16'h0001, 16'h0001, 0, 2, 0, 0), 1'b0);
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (!(rsp_valid && rsp_data == 16'h0001 && !rsp_carry && !cmd_ready && !we)) ok = 1'b0;
        end
        chk("stall_hold", ok, 1);
        chk("stall_no_write", wcnt - w0, 0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_idle", {cmd_ready, rsp_valid}, 2'b10);

        // reset landing in WB drops the command
        w0 = wcnt;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = ADD; cmd_rs = 2; cmd_rt = 2; cmd_rd = 2;
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("wb_reached", {we, wr_regnum}, {1'b1, 5'd2});
        reset = 1'b1;
        #1;
        chk("reset_kills_we", we, 0);
        @(posedge clk); #1 reset = 1'b0;
        chk("after_reset_idle", {cmd_ready, rsp_valid, we}, 3'b100);
        ok = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid) ok = 1'b0;
        end
        chk("no_dropped_response", ok, 1);
        chk("no_dropped_write", wcnt - w0, 0);
        run(mk(RD, 2, 0, 0, 16'h0000, 16'h8002, 16'h8002, 0, 2, 0, 0), 1'b1);

        chk("regnum_upper_bits", hi_bits, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
